// File: rtl/count_seq_checker.sv
// count_seq_checker: monitors a stream of wrap-around counter values and checks that each
// valid sample is the previous one plus 1, modulo 2^WIDTH. After LOCK_CNT consecutive
// correct increments it declares lock. While locked it flags sequence breaks, flags wraps
// from max to 0, and keeps a saturating tally of breaks.
//
// Ports:
//   clk          rising-edge clock
//   reset        synchronous active-high reset
//   q_in         observed counter value
//   q_valid      q_in is sampled on this edge when high
//   locked       checker is locked onto the sequence
//   expected     prev+1 mod 2^WIDTH; 0 until the first sample
//   err_pulse    one-cycle pulse on a sequence break while locked
//   wrap_pulse   one-cycle pulse on a locked wrap from max to 0
//   err_count    saturating count of err_pulse events
//   resync_pulse (only with CNT_CHK_RESET_TOLERANT_EN) one-cycle pulse when a locked
//                stream restarts at 0, which is treated as an upstream counter reset
//
// Optional feature macro: CNT_CHK_RESET_TOLERANT_EN.

module count_seq_checker #(
    parameter int unsigned WIDTH    = 4,
    parameter int unsigned LOCK_CNT = 2,   // 1..15
    parameter int unsigned ERRW     = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] q_in,
    input  logic             q_valid,
    output logic             locked,
    output logic [WIDTH-1:0] expected,
    output logic             err_pulse,
    output logic             wrap_pulse,
`ifdef CNT_CHK_RESET_TOLERANT_EN
    output logic             resync_pulse,
`endif
    output logic [ERRW-1:0]  err_count
);

    localparam int unsigned RUNW = 4;

    typedef enum logic [0:0] {StSearch, StLocked} state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] prev_q, prev_d;
    logic             have_prev_q, have_prev_d;
    logic [RUNW-1:0]  run_q, run_d;
    logic [WIDTH-1:0] expected_q, expected_d;
    logic             err_pulse_q, err_pulse_d;
    logic             wrap_pulse_q, wrap_pulse_d;
    logic [ERRW-1:0]  err_count_q, err_count_d;
`ifdef CNT_CHK_RESET_TOLERANT_EN
    logic             resync_pulse_q, resync_pulse_d;
`endif

    logic             inc;
    logic [RUNW-1:0]  run_inc;
    logic [ERRW:0]    err_inc;   // one bit wider so saturation can be seen as a carry-out

    assign inc     = have_prev_q && (q_in == prev_q + WIDTH'(1));
    assign run_inc = run_q + RUNW'(1);
    assign err_inc = {1'b0, err_count_q} + (ERRW+1)'(1);

    always_comb begin
        state_d        = state_q;
        prev_d         = prev_q;
        have_prev_d    = have_prev_q;
        run_d          = run_q;
        expected_d     = expected_q;
        err_count_d    = err_count_q;
        err_pulse_d    = 1'b0;
        wrap_pulse_d   = 1'b0;
`ifdef CNT_CHK_RESET_TOLERANT_EN
        resync_pulse_d = 1'b0;
`endif
        if (q_valid) begin
            prev_d      = q_in;
            have_prev_d = 1'b1;
            expected_d  = q_in + WIDTH'(1);
            unique case (state_q)
                StSearch: begin
                    if (inc) begin
                        if (run_inc == RUNW'(LOCK_CNT)) begin
                            state_d = StLocked;
                            run_d   = '0;
                        end else begin
                            run_d = run_inc;
                        end
                    end else begin
                        run_d = '0;
                    end
                end
                StLocked: begin
                    if (inc) begin
                        wrap_pulse_d = (prev_q == {WIDTH{1'b1}}) && (q_in == '0);
`ifdef CNT_CHK_RESET_TOLERANT_EN
                    end else if (q_in == '0) begin
                        // Upstream counter restarted: follow it without counting an error.
                        resync_pulse_d = 1'b1;
`endif
                    end else begin
                        err_pulse_d = 1'b1;
                        if (!err_inc[ERRW]) begin
                            err_count_d = err_inc[ERRW-1:0];
                        end
                        // The failing sample stays as prev so relock can start from it.
                        state_d = StSearch;
                        run_d   = '0;
                    end
                end
                default: state_d = StSearch;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= StSearch;
            prev_q         <= '0;
            have_prev_q    <= 1'b0;
            run_q          <= '0;
            expected_q     <= '0;
            err_pulse_q    <= 1'b0;
            wrap_pulse_q   <= 1'b0;
            err_count_q    <= '0;
`ifdef CNT_CHK_RESET_TOLERANT_EN
            resync_pulse_q <= 1'b0;
`endif
        end else begin
            state_q        <= state_d;
            prev_q         <= prev_d;
            have_prev_q    <= have_prev_d;
            run_q          <= run_d;
            expected_q     <= expected_d;
            err_pulse_q    <= err_pulse_d;
            wrap_pulse_q   <= wrap_pulse_d;
            err_count_q    <= err_count_d;
`ifdef CNT_CHK_RESET_TOLERANT_EN
            resync_pulse_q <= resync_pulse_d;
`endif
        end
    end

    assign locked       = (state_q == StLocked);
    assign expected     = expected_q;
    assign err_pulse    = err_pulse_q;
    assign wrap_pulse   = wrap_pulse_q;
    assign err_count    = err_count_q;
`ifdef CNT_CHK_RESET_TOLERANT_EN
    assign resync_pulse = resync_pulse_q;
`endif

endmodule

// File: tb/tb_count_seq_checker.sv
// Directed testbench for count_seq_checker (WIDTH=4, LOCK_CNT=2, ERRW=8).
module tb_count_seq_checker;

    logic       clk;
    logic       reset;
    logic [3:0] q_in;
    logic       q_valid;
    logic       locked;
    logic [3:0] expected;
    logic       err_pulse;
    logic       wrap_pulse;
    logic [7:0] err_count;
`ifdef CNT_CHK_RESET_TOLERANT_EN
    logic       resync_pulse;
`endif

    int checks = 0;
    int errors = 0;

    count_seq_checker #(
        .WIDTH    (4),
        .LOCK_CNT (2),
        .ERRW     (8)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .q_in         (q_in),
        .q_valid      (q_valid),
        .locked       (locked),
        .expected     (expected),
        .err_pulse    (err_pulse),
        .wrap_pulse   (wrap_pulse),
`ifdef CNT_CHK_RESET_TOLERANT_EN
        .resync_pulse (resync_pulse),
`endif
        .err_count    (err_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s got %0d want %0d", tag, got, exp);
        end
    endtask

    // Apply one edge of stimulus, then sample 1 time unit after the edge.
    task automatic step(input logic rst, input logic vld, input logic [3:0] val);
        reset   = rst;
        q_valid = vld;
        q_in    = val;
        @(posedge clk);
        #1;
        reset   = 1'b0;
        q_valid = 1'b0;
    endtask

    task automatic do_reset();
        step(1'b1, 1'b0, 4'd0);
    endtask

    initial begin
        logic [3:0] p;
        int         model_err;
        reset   = 1'b1;
        q_valid = 1'b0;
        q_in    = '0;

        // Reset state
        do_reset();
        check_val("rst_locked", locked, 0);
        check_val("rst_expected", expected, 0);
        check_val("rst_err_pulse", err_pulse, 0);
        check_val("rst_wrap_pulse", wrap_pulse, 0);
        check_val("rst_err_count", err_count, 0);

        // 1: 0..15,0,1 locks on sample 2, one wrap pulse
        for (int i = 0; i < 16; i++) begin
            step(1'b0, 1'b1, 4'(i));
            check_val($sformatf("t1_locked_%0d", i), locked, (i >= 2) ? 1 : 0);
            check_val($sformatf("t1_wrap_%0d", i), wrap_pulse, 0);
            check_val($sformatf("t1_exp_%0d", i), expected, (i + 1) % 16);
        end
        step(1'b0, 1'b1, 4'd0);
        check_val("t1_wrap_at_0", wrap_pulse, 1);
        check_val("t1_locked_at_0", locked, 1);
        step(1'b0, 1'b1, 4'd1);
        check_val("t1_wrap_after", wrap_pulse, 0);
        check_val("t1_expected_end", expected, 2);
        check_val("t1_err_count", err_count, 0);

        // 2: locked at 5, then 7,8,9
        for (int i = 2; i <= 5; i++) step(1'b0, 1'b1, 4'(i));
        check_val("t2_locked_5", locked, 1);
        step(1'b0, 1'b1, 4'd7);
        check_val("t2_err_pulse_7", err_pulse, 1);
        check_val("t2_err_count_7", err_count, 1);
        check_val("t2_locked_7", locked, 0);
        check_val("t2_expected_7", expected, 8);
        step(1'b0, 1'b1, 4'd8);
        check_val("t2_err_pulse_8", err_pulse, 0);
        check_val("t2_locked_8", locked, 0);
        step(1'b0, 1'b1, 4'd9);
        check_val("t2_locked_9", locked, 1);
        check_val("t2_err_count_9", err_count, 1);

        // 3: locked at 3, 4-cycle gap, then 4
        do_reset();
        for (int i = 1; i <= 3; i++) step(1'b0, 1'b1, 4'(i));
        check_val("t3_locked_3", locked, 1);
        for (int i = 0; i < 4; i++) begin
            step(1'b0, 1'b0, 4'd9);
            check_val($sformatf("t3_gap_locked_%0d", i), locked, 1);
            check_val($sformatf("t3_gap_expected_%0d", i), expected, 4);
            check_val($sformatf("t3_gap_err_%0d", i), err_pulse, 0);
        end
        step(1'b0, 1'b1, 4'd4);
        check_val("t3_err_4", err_pulse, 0);
        check_val("t3_locked_4", locked, 1);
        check_val("t3_expected_4", expected, 5);

        // 4: locked at 10 with one error, reset overriding a valid 11
        do_reset();
        for (int i = 8; i <= 10; i++) step(1'b0, 1'b1, 4'(i));
        step(1'b0, 1'b1, 4'd3);
        check_val("t4_err_count_pre", err_count, 1);
        for (int i = 4; i <= 6; i++) step(1'b0, 1'b1, 4'(i));
        check_val("t4_locked_pre", locked, 1);
        step(1'b1, 1'b1, 4'd11);
        check_val("t4_rst_locked", locked, 0);
        check_val("t4_rst_expected", expected, 0);
        check_val("t4_rst_err_count", err_count, 0);
        check_val("t4_rst_err_pulse", err_pulse, 0);
        check_val("t4_rst_wrap", wrap_pulse, 0);
        step(1'b0, 1'b1, 4'd0);
        check_val("t4_locked_0", locked, 0);
        step(1'b0, 1'b1, 4'd1);
        check_val("t4_locked_1", locked, 0);
        step(1'b0, 1'b1, 4'd2);
        check_val("t4_locked_2", locked, 1);
        check_val("t4_err_count", err_count, 0);

        // 5: 300 lock/error cycles saturate err_count at 255
        p         = 4'd2;
        model_err = 0;
        for (int i = 0; i < 300; i++) begin
            p = p + 4'd5;
            step(1'b0, 1'b1, p);
            model_err = (model_err < 255) ? model_err + 1 : 255;
            check_val($sformatf("t5_err_pulse_%0d", i), err_pulse, 1);
            check_val($sformatf("t5_err_count_%0d", i), err_count, model_err);
            p = p + 4'd1;
            step(1'b0, 1'b1, p);
            p = p + 4'd1;
            step(1'b0, 1'b1, p);
            check_val($sformatf("t5_relock_%0d", i), locked, 1);
        end
        check_val("t5_sat_final", err_count, 255);

        // 6: locked at 6, then 0,1
        do_reset();
        for (int i = 4; i <= 6; i++) step(1'b0, 1'b1, 4'(i));
        check_val("t6_locked_6", locked, 1);
        step(1'b0, 1'b1, 4'd0);
`ifdef CNT_CHK_RESET_TOLERANT_EN
        check_val("t6_resync_0", resync_pulse, 1);
        check_val("t6_err_pulse_0", err_pulse, 0);
        check_val("t6_locked_0", locked, 1);
        check_val("t6_err_count_0", err_count, 0);
        check_val("t6_wrap_0", wrap_pulse, 0);
        step(1'b0, 1'b1, 4'd1);
        check_val("t6_resync_1", resync_pulse, 0);
        check_val("t6_locked_1", locked, 1);
        check_val("t6_err_count_1", err_count, 0);
`else
        check_val("t6_err_pulse_0", err_pulse, 1);
        check_val("t6_locked_0", locked, 0);
        check_val("t6_err_count_0", err_count, 1);
        step(1'b0, 1'b1, 4'd1);
        check_val("t6_err_pulse_1", err_pulse, 0);
        check_val("t6_locked_1", locked, 0);
        check_val("t6_err_count_1", err_count, 1);
`endif
        check_val("t6_expected_1", expected, 2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
